imem_loader: RTL

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit little-endian words. Writes those words into the instruction memory's write port while holding the CPU core in reset. Releases the core once the full program image has been written; the fetch/decode path then reads the memory through its normal read port.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader that fills instruction memory and holds the core in reset
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    MEM_ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  // One extra index bit so a full-capacity image never wraps before its last write.
  localparam int          IW  = MEM_ADDR_WIDTH + 1;
  localparam logic [32:0] CAP = 33'd1 << MEM_ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
  logic [7:0] csum_q, csum_d;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [31:0]           len_q, len_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  xfer;
  logic [31:0]           n_full;
  logic [IW-1:0]         idx_inc;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    xfer    = in_valid && in_ready_q;
    n_full  = {in_data, len_q[23:0]};
    idx_inc = idx_q + IW'(1);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          idx_d      = '0;
          len_d      = '0;
          mem_addr_d = BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          len_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            if ({1'b0, n_full} > CAP) state_d = S_ERR;
            else if (n_full == 32'd0) state_d = S_END;
            else state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_wdata_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d      = idx_inc;
        mem_addr_d = mem_addr_q + DATA_WIDTH'(4);
        if ({{(32-IW){1'b0}}, idx_inc} == len_q) state_d = S_END;
        else state_d = S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Every output is a function of the next state, so all of them register together.
    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
    mem_we_d   = (state_d == S_WRITE);
    busy_d     = in_ready_d || mem_we_d;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      idx_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_hold_q  <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_hold  = cpu_hold_q;

endmodule
